// File: rtl/bullet_collision_scanner.sv
// Walks every bullet slot on the table's second read port, one per cycle, and hits the heart on box overlap.
// Optional hit-invulnerability window is compiled in with `define COLLIDE_INVULN_EN.
module bullet_collision_scanner #(
    parameter int          NUM_BULLETS   = 3,
    parameter logic [7:0]  HP_INIT       = 8'd100,
    parameter logic [7:0]  DAMAGE        = 8'd5,
    parameter logic [15:0] INVULN_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isRun,
    output logic [2:0]  index2,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic        isRender2,
    input  logic [15:0] playerPos,
    input  logic [15:0] playerSize,
    output logic        isCollide,
    output logic [7:0]  hp,
    output logic        isDead,
    output logic        hitPulse
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DEAD
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_BULLETS - 1);

    state_t     state_reg, state_next;
    logic [2:0] index_reg, index_next;
    logic       collide_reg, collide_next;
    logic [7:0] hp_reg, hp_next;
    logic       dead_reg, dead_next;

    logic [1:0] axis_ok;
    logic       overlap;
    logic       hit;
    logic       scan_hit;
    logic [7:0] hp_after;

    // Axis 0 is y (low byte), axis 1 is x (high byte); 9-bit ends avoid 8-bit wrap.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_axis
        logic [7:0] b_lo, b_len, p_lo, p_len;
        logic [8:0] b_end, p_end;

        assign b_lo  = position2[gi*8 +: 8];
        assign b_len = size2[gi*8 +: 8];
        assign p_lo  = playerPos[gi*8 +: 8];
        assign p_len = playerSize[gi*8 +: 8];
        assign b_end = {1'b0, b_lo} + {1'b0, b_len};
        assign p_end = {1'b0, p_lo} + {1'b0, p_len};
        // Zero extents are rejected explicitly: a zero-width box can still satisfy both strict compares.
        assign axis_ok[gi] = (b_len != 8'd0) && (p_len != 8'd0)
                          && ({1'b0, p_lo} < b_end) && ({1'b0, b_lo} < p_end);
    end

    assign overlap = isRender2 && (&axis_ok);

`ifdef COLLIDE_INVULN_EN
    logic [15:0] inv_reg, inv_next;

    assign hit = overlap && (inv_reg == 16'd0);

    always_comb begin
        inv_next = (inv_reg != 16'd0) ? inv_reg - 16'd1 : 16'd0;
        if (!isRun || state_reg == IDLE) begin
            inv_next = 16'd0;
        end else if (scan_hit) begin
            inv_next = INVULN_CYCLES;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inv_reg <= 16'd0;
        end else begin
            inv_reg <= inv_next;
        end
    end
`else
    assign hit = overlap;
`endif

    assign scan_hit = isRun && (state_reg == SCAN) && hit;
    assign hp_after = (hp_reg > DAMAGE) ? hp_reg - DAMAGE : 8'd0;

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        collide_next = 1'b0;
        hp_next      = hp_reg;
        dead_next    = dead_reg;
        if (!isRun) begin
            // Dropping isRun abandons any hit under evaluation this cycle.
            state_next = IDLE;
            index_next = 3'd0;
            hp_next    = HP_INIT;
            dead_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = SCAN;
                    index_next = 3'd0;
                    hp_next    = HP_INIT;
                    dead_next  = 1'b0;
                end
                SCAN: begin
                    index_next = (index_reg == LAST_IDX) ? 3'd0 : index_reg + 3'd1;
                    if (scan_hit) begin
                        collide_next = 1'b1;
                        hp_next      = hp_after;
                        if (hp_after == 8'd0) begin
                            state_next = DEAD;
                            index_next = 3'd0;
                            dead_next  = 1'b1;
                        end
                    end
                end
                DEAD: begin
                    index_next = 3'd0;
                    dead_next  = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                    index_next = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            index_reg   <= 3'd0;
            collide_reg <= 1'b0;
            hp_reg      <= HP_INIT;
            dead_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            collide_reg <= collide_next;
            hp_reg      <= hp_next;
            dead_reg    <= dead_next;
        end
    end

    assign index2    = index_reg;
    assign isCollide = collide_reg;
    assign hitPulse  = collide_reg;
    assign hp        = hp_reg;
    assign isDead    = dead_reg;

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Directed bench for bullet_collision_scanner with a small bullet-table model on the second read port.
module tb_bullet_collision_scanner;

    logic        clk;
    logic        reset;
    logic        isRun;
    logic [2:0]  index2;
    logic [15:0] position2;
    logic [15:0] size2;
    logic        isRender2;
    logic [15:0] playerPos;
    logic [15:0] playerSize;
    logic        isCollide;
    logic [7:0]  hp;
    logic        isDead;
    logic        hitPulse;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Bullet table model: static slot contents plus a clear mask driven by isCollide.
    logic [15:0] pos_a  [8];
    logic [15:0] size_a [8];
    logic [7:0]  rend_v;
    logic [7:0]  clr_mask;
    logic [2:0]  prev_idx;
    logic        clear_en;
    logic        tbl_reload;

    bullet_collision_scanner #(
        .NUM_BULLETS  (3),
        .HP_INIT      (8'd100),
        .DAMAGE       (8'd5),
        .INVULN_CYCLES(16'd10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .isRun     (isRun),
        .index2    (index2),
        .position2 (position2),
        .size2     (size2),
        .isRender2 (isRender2),
        .playerPos (playerPos),
        .playerSize(playerSize),
        .isCollide (isCollide),
        .hp        (hp),
        .isDead    (isDead),
        .hitPulse  (hitPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign position2 = pos_a[index2];
    assign size2     = size_a[index2];
    assign isRender2 = rend_v[index2] & ~clr_mask[index2];

    always @(posedge clk) begin
        prev_idx <= index2;
        if (tbl_reload) begin
            clr_mask <= 8'd0;
        end else if (isCollide && clear_en) begin
            clr_mask[prev_idx] <= 1'b1;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 8; i++) begin
            pos_a[i]  = 16'h0000;
            size_a[i] = 16'h0000;
        end
        rend_v = 8'd0;
    endtask

    task automatic go_idle();
        isRun      = 1'b0;
        tbl_reload = 1'b1;
        @(negedge clk);
        tbl_reload = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first SCAN cycle (index2 = 0).
    task automatic start_run();
        isRun = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        isRun = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (index2 !== 3'd0 || isCollide !== 1'b0 || hitPulse !== 1'b0 || hp !== 8'd100 || isDead !== 1'b0)
            $display("FAIL reset_state: idx=%0d col=%b hit=%b hp=%0d dead=%b, required idx=0 col=0 hit=0 hp=100 dead=0",
                     index2, isCollide, hitPulse, hp, isDead);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (hp !== 8'd100 || index2 !== 3'd0)
            $display("FAIL idle_after_reset: hp=%0d idx=%0d, required hp=100 idx=0", hp, index2);
        else pass_cnt++;
    endtask

    task automatic test_scan_order();
        clear_table();
        clear_en = 1'b1;
        playerPos = 16'hA818;
        playerSize = 16'h0808;
        go_idle();
        start_run();
        for (int j = 0; j < 7; j++) begin
            total_cnt++;
            if (index2 !== 3'(j % 3) || isCollide !== 1'b0)
                $display("FAIL scan_order[%0d]: idx=%0d col=%b, required idx=%0d col=0", j, index2, isCollide, j % 3);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (hp !== 8'd100)
            $display("FAIL scan_hp: hp=%0d, required 100", hp);
        else pass_cnt++;
    endtask

    task automatic test_hit();
        clear_table();
        clear_en = 1'b1;
        pos_a[1] = 16'hA013;
        size_a[1] = 16'h1010;
        rend_v[1] = 1'b1;
        playerPos = 16'hA818;
        playerSize = 16'h0808;
        go_idle();
        start_run();
        @(negedge clk);
        total_cnt++;
        if (index2 !== 3'd1 || isCollide !== 1'b0)
            $display("FAIL hit_eval_cycle: idx=%0d col=%b, required idx=1 col=0", index2, isCollide);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (isCollide !== 1'b1 || hitPulse !== 1'b1 || hp !== 8'd95)
            $display("FAIL hit_pulse: col=%b hit=%b hp=%0d, required col=1 hit=1 hp=95", isCollide, hitPulse, hp);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (isCollide !== 1'b0 || hitPulse !== 1'b0)
            $display("FAIL hit_one_cycle: col=%b hit=%b, required 0 0", isCollide, hitPulse);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (hp !== 8'd95 || isCollide !== 1'b0)
            $display("FAIL hit_cleared_slot: hp=%0d col=%b, required hp=95 col=0", hp, isCollide);
        else pass_cnt++;
    endtask

    task automatic run_no_hit(input string name, input logic [15:0] bsize, input logic [15:0] ppos);
        int hits;
        clear_table();
        clear_en = 1'b1;
        pos_a[1] = 16'hA013;
        size_a[1] = bsize;
        rend_v[1] = 1'b1;
        playerPos = ppos;
        playerSize = 16'h0808;
        go_idle();
        start_run();
        hits = 0;
        for (int j = 0; j < 7; j++) begin
            if (isCollide) hits++;
            @(negedge clk);
        end
        total_cnt++;
        if (hits != 0 || hp !== 8'd100)
            $display("FAIL %s: hits=%0d hp=%0d, required hits=0 hp=100", name, hits, hp);
        else pass_cnt++;
    endtask

    task automatic test_boundaries();
        run_no_hit("edge_touch_x", 16'h1010, 16'hB018);
        run_no_hit("edge_touch_y", 16'h1010, 16'hA823);
        run_no_hit("zero_width", 16'h0010, 16'h9C18);
    endtask

    task automatic test_dead();
        int hits;
        clear_table();
        clear_en = 1'b0;
        pos_a[0] = 16'hA013;
        size_a[0] = 16'h1010;
        rend_v[0] = 1'b1;
        playerPos = 16'hA818;
        playerSize = 16'h0808;
        go_idle();
        start_run();
        hits = 0;
        for (int c = 0; c < 80 && isDead !== 1'b1; c++) begin
            @(negedge clk);
            if (isCollide === 1'b1) begin
                hits++;
                total_cnt++;
                if (hp !== 8'(100 - 5 * hits))
                    $display("FAIL dead_hp_step[%0d]: hp=%0d, required %0d", hits, hp, 100 - 5 * hits);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (hits != 20 || isDead !== 1'b1 || hp !== 8'd0)
            $display("FAIL dead_reached: hits=%0d dead=%b hp=%0d, required hits=20 dead=1 hp=0", hits, isDead, hp);
        else pass_cnt++;
        hits = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (isCollide !== 1'b0 || hitPulse !== 1'b0 || index2 !== 3'd0) hits++;
        end
        total_cnt++;
        if (hits != 0 || isDead !== 1'b1 || hp !== 8'd0)
            $display("FAIL dead_frozen: bad_cycles=%0d dead=%b hp=%0d, required 0 1 0", hits, isDead, hp);
        else pass_cnt++;
    endtask

    task automatic test_run_drop();
        clear_table();
        clear_en = 1'b0;
        pos_a[1] = 16'hA013;
        size_a[1] = 16'h1010;
        rend_v[1] = 1'b1;
        playerPos = 16'hA818;
        playerSize = 16'h0808;
        go_idle();
        start_run();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (hp !== 8'd95)
            $display("FAIL drop_prehit: hp=%0d, required 95", hp);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (index2 !== 3'd1)
            $display("FAIL drop_eval_idx: idx=%0d, required 1", index2);
        else pass_cnt++;
        isRun = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (isCollide !== 1'b0 || hp !== 8'd100 || isDead !== 1'b0 || index2 !== 3'd0)
            $display("FAIL drop_to_idle: col=%b hp=%0d dead=%b idx=%0d, required 0 100 0 0",
                     isCollide, hp, isDead, index2);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (isCollide !== 1'b0 || hp !== 8'd100)
            $display("FAIL drop_stays_idle: col=%b hp=%0d, required 0 100", isCollide, hp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int hits;
        int last_hit;
        int min_gap;
        int gap_ok;
        clear_table();
        clear_en = 1'b0;
        pos_a[0] = 16'hA013;
        size_a[0] = 16'h1010;
        rend_v[0] = 1'b1;
        playerPos = 16'hA818;
        playerSize = 16'h0808;
        go_idle();
        start_run();
        hits = 0;
        last_hit = -100;
        min_gap = 1000;
        gap_ok = 1;
        for (int t = 2; t <= 40; t++) begin
            @(negedge clk);
            if (isCollide === 1'b1) begin
                if (hits > 0 && (t - last_hit) < min_gap) min_gap = t - last_hit;
`ifndef COLLIDE_INVULN_EN
                if (t != 3 * (hits + 1) - 1) gap_ok = 0;
`endif
                hits++;
                last_hit = t;
            end
        end
`ifdef COLLIDE_INVULN_EN
        total_cnt++;
        if (hits < 2 || min_gap < 11)
            $display("FAIL invuln_spacing: hits=%0d min_gap=%0d, required hits>=2 gap>=11", hits, min_gap);
        else pass_cnt++;
`else
        total_cnt++;
        if (hits != 13 || gap_ok != 1 || min_gap != 3)
            $display("FAIL per_rev_hits: hits=%0d min_gap=%0d on_schedule=%0d, required 13 3 1", hits, min_gap, gap_ok);
        else pass_cnt++;
        total_cnt++;
        if (hp !== 8'd35)
            $display("FAIL per_rev_hp: hp=%0d, required 35", hp);
        else pass_cnt++;
`endif
    endtask

    initial begin
        reset = 1'b1;
        isRun = 1'b0;
        clear_en = 1'b1;
        tbl_reload = 1'b1;
        playerPos = 16'h0000;
        playerSize = 16'h0000;
        clear_table();
        @(negedge clk);
        tbl_reload = 1'b0;
        test_reset();
        test_scan_order();
        test_hit();
        test_boundaries();
        test_dead();
        test_run_drop();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
